// File: rtl/dt1_mem_stage.sv
// Memory stage of the RV32I 5-stage pipeline plus the MEM/WB pipeline register.
// Requests go out on a ready-handshaked data bus. While an access is outstanding
// the upstream stages are stalled. An access that gets no response is abandoned
// after TIMEOUT_CYCLES wait cycles.
module dt1_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // Copies of the access taken in IDLE, replayed on the bus while in WAIT
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic [2:0]  funct3_reg;

    logic        is_mem_m;
    logic        misalign_m;
    logic [31:0] wdata_m;
    logic [3:0]  be_m;
    logic        bubble;

    logic [31:0] cur_addr;
    logic [2:0]  cur_funct3;
    logic [1:0]  cur_lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign is_mem_m = MemWriteM | (ResultSrcM == 2'b01);

    // Halfwords need bit 0 clear; words need both low bits clear
    assign misalign_m = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                        ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));

    // Per-lane store data replication and byte enables; loads enable all lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_m[gi*8 +: 8] = (Funct3M[1:0] == 2'b00) ? WriteDataM[7:0] :
                                    (Funct3M[1:0] == 2'b01) ? WriteDataM[(gi%2)*8 +: 8] :
                                                              WriteDataM[gi*8 +: 8];
        assign be_m[gi] = !MemWriteM                 ? 1'b1 :
                          (Funct3M[1:0] == 2'b00)    ? (ALUResultM[1:0] == 2'(gi)) :
                          (Funct3M[1:0] == 2'b01)    ? (ALUResultM[1] == 1'(gi / 2)) :
                                                       1'b1;
    end

    // Bus is driven straight from the *M inputs in IDLE and from the latched copies in WAIT
    always_comb begin
        if (state_reg == ST_WAIT) begin
            cur_addr   = addr_reg;
            cur_funct3 = funct3_reg;
            dmem_we    = we_reg;
            dmem_wdata = wdata_reg;
            dmem_be    = be_reg;
        end else begin
            cur_addr   = ALUResultM;
            cur_funct3 = Funct3M;
            dmem_we    = MemWriteM;
            dmem_wdata = wdata_m;
            dmem_be    = be_m;
        end
        cur_lane  = cur_addr[1:0];
        dmem_addr = {cur_addr[31:2], 2'b00};
    end

    // Load alignment and sign/zero extension
    always_comb begin
        byte_sel = dmem_rdata[{cur_lane, 3'b000} +: 8];
        half_sel = dmem_rdata[{cur_lane[1], 4'b0000} +: 16];
        case (cur_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // Access FSM: next state, timeout counter, handshake and status pulses
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dmem_req   = 1'b0;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        BusErrM    = 1'b0;
        bubble     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (is_mem_m) begin
                    if (misalign_m) begin
                        MisalignM = 1'b1;
                        bubble    = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        if (!dmem_ready) begin
                            StallM     = 1'b1;
                            bubble     = 1'b1;
                            state_next = ST_WAIT;
                            count_next = '0;
                        end
                    end
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (count_reg == CNT_LAST) begin
                    // Last allowed wait cycle with no response: give up and retire a bubble
                    BusErrM    = 1'b1;
                    bubble     = 1'b1;
                    state_next = ST_IDLE;
                    count_next = '0;
                end else begin
                    StallM     = 1'b1;
                    bubble     = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // State and timeout counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Capture the access every IDLE cycle so WAIT can replay it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            be_reg     <= '0;
            funct3_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            addr_reg   <= ALUResultM;
            we_reg     <= MemWriteM;
            wdata_reg  <= wdata_m;
            be_reg     <= be_m;
            funct3_reg <= Funct3M;
        end
    end

    // MEM/WB register: loads every cycle, inserting a bubble on stall, misalign or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
        end else begin
            RegWriteW  <= bubble ? 1'b0 : RegWriteM;
            RdW        <= bubble ? 5'd0 : RdM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
            PCPlus4W   <= PCPlus4M;
        end
    end

endmodule

// File: tb/tb_dt1_mem_stage.sv
// Self-checking bench for dt1_mem_stage: directed cases plus randomized
// instructions checked against a behavioural model of the memory stage.
module tb_dt1_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered by the issue driver
    logic        o_req0, o_we0, o_mis, o_berr, o_addr_moved, o_hung;
    logic [31:0] o_addr0, o_wdata0;
    logic [3:0]  o_be0;
    int          o_stall, o_bubbles_bad;

    always #5 clk = ~clk;

    dt1_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW)
    );

    // ---------------- reference model ----------------
    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        if (f3 == 3'b010) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a,
                                          input logic store);
        if (!store) return 4'hF;
        if (f3 == 3'b000) return 4'b0001 << a[1:0];
        if (f3 == 3'b001) return 4'b0011 << a[1:0];
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'b000) return (wd & 32'hFF) * 32'h01010101;
        if (f3 == 3'b001) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // ---------------- stimulus driver ----------------
    task automatic set_nop();
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        PCPlus4M   = 32'd0;
        RdM        = 5'd0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
    endtask

    // Called just after a rising edge. Presents one instruction, answers the bus
    // with ready after 'lat' wait cycles, and returns just after the edge that
    // loads the instruction (or its bubble) into MEM/WB.
    task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input int lat, input logic [31:0] rdata);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        Funct3M    = f3;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
        RdM        = rd;
        dmem_rdata = rdata;
        dmem_ready = (lat == 0);
        o_stall = 0; o_bubbles_bad = 0; o_addr_moved = 1'b0; o_hung = 1'b0;
        @(negedge clk);
        o_req0   = dmem_req;
        o_we0    = dmem_we;
        o_addr0  = dmem_addr;
        o_be0    = dmem_be;
        o_wdata0 = dmem_wdata;
        while (StallM === 1'b1 && !o_hung) begin
            o_stall++;
            if (dmem_addr !== o_addr0) o_addr_moved = 1'b1;
            @(posedge clk); #1;
            if (RegWriteW !== 1'b0) o_bubbles_bad++;
            dmem_ready = (o_stall == lat);
            @(negedge clk);
            if (o_stall > 40) o_hung = 1'b1;
        end
        o_mis  = MisalignM;
        o_berr = BusErrM;
        @(posedge clk); #1;
        set_nop();
        $display("[TB] txn rs=%0d mw=%0d f3=%0d addr=%h lat=%0d stall=%0d", rs, mw, f3, alu, lat, o_stall);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset      = 1'b1;
        set_nop();
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b10;
        ALUResultM = 32'h1357_9BDF;
        PCPlus4M   = 32'h0000_0044;
        RdM        = 5'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_w: got rw=%b rs=%b alu=%h rd=%h pc4=%h rdw=%0d, expected all 0",
                     RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW);
        end
        reset = 1'b0;
        set_nop();
        @(negedge clk);
        n_tests++;
        if ({dmem_req, StallM, MisalignM, BusErrM} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req/stall/mis/berr=%b, expected 0000",
                     {dmem_req, StallM, MisalignM, BusErrM});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'd0, 32'h104, 5'd5, 0, 32'hDEADBEEF);
        n_tests++;
        if ({ReadDataW, ResultSrcW, RegWriteW, RdW} !== {32'hDEADBEEF, 2'b01, 1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL lw_data: got data=%h rs=%b rw=%b rd=%0d, expected deadbeef 01 1 5",
                     ReadDataW, ResultSrcW, RegWriteW, RdW);
        end
        n_tests++;
        if (o_stall !== 0 || o_req0 !== 1'b1 || o_we0 !== 1'b0 || o_be0 !== 4'hF) begin
            n_fail++;
            $display("FAIL lw_bus: got stall=%0d req=%b we=%b be=%b, expected 0 1 0 1111",
                     o_stall, o_req0, o_we0, o_be0);
        end
        issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'd0, 32'h108, 5'd6, 0, 32'h80FFFFFF);
        n_tests++;
        if (ReadDataW !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL lb: got %h, expected ffffff80", ReadDataW);
        end
        issue(1'b1, 2'b01, 1'b0, 3'b100, 32'h103, 32'd0, 32'h10C, 5'd6, 0, 32'h80FFFFFF);
        n_tests++;
        if (ReadDataW !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu: got %h, expected 00000080", ReadDataW);
        end
        issue(1'b1, 2'b01, 1'b0, 3'b101, 32'h102, 32'd0, 32'h110, 5'd6, 0, 32'h80FFFFFF);
        n_tests++;
        if (ReadDataW !== 32'h000080FF) begin
            n_fail++;
            $display("FAIL lhu: got %h, expected 000080ff", ReadDataW);
        end
    endtask

    task automatic test_store();
        issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h114, 5'd0, 0, 32'd0);
        n_tests++;
        if ({o_req0, o_we0, o_be0, o_wdata0, o_addr0} !== {1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100}) begin
            n_fail++;
            $display("FAIL sh_bus: got req=%b we=%b be=%b wdata=%h addr=%h, expected 1 1 1100 abcdabcd 00000100",
                     o_req0, o_we0, o_be0, o_wdata0, o_addr0);
        end
        n_tests++;
        if (RegWriteW !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_regwrite: got %b, expected 0", RegWriteW);
        end
    endtask

    task automatic test_stall();
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'd0, 32'h118, 5'd11, 3, 32'h11223344);
        n_tests++;
        if (o_stall !== 3 || o_hung !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d cycles (hung=%b), expected 3", o_stall, o_hung);
        end
        n_tests++;
        if (o_addr_moved !== 1'b0 || o_bubbles_bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got addr_moved=%b bad_bubbles=%0d, expected 0 0",
                     o_addr_moved, o_bubbles_bad);
        end
        n_tests++;
        if ({ReadDataW, RegWriteW, RdW} !== {32'h11223344, 1'b1, 5'd11}) begin
            n_fail++;
            $display("FAIL stall_data: got data=%h rw=%b rd=%0d, expected 11223344 1 11",
                     ReadDataW, RegWriteW, RdW);
        end
    endtask

    task automatic test_misalign();
        issue(1'b1, 2'b01, 1'b0, 3'b001, 32'h101, 32'd0, 32'h11C, 5'd12, 0, 32'h55555555);
        n_tests++;
        if ({o_req0, o_mis, RegWriteW, RdW, 1'(o_stall != 0)} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL misalign_lh: got req=%b mis=%b rw=%b rd=%0d stall=%0d, expected 0 1 0 0 0",
                     o_req0, o_mis, RegWriteW, RdW, o_stall);
        end
        issue(1'b1, 2'b00, 1'b0, 3'b000, 32'hCAFE0001, 32'd0, 32'h120, 5'd9, 0, 32'd0);
        n_tests++;
        if ({RegWriteW, RdW, ResultSrcW, ALUResultW, PCPlus4W, o_req0, o_mis} !==
            {1'b1, 5'd9, 2'b00, 32'hCAFE0001, 32'h120, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_pass: got rw=%b rd=%0d rs=%b alu=%h pc4=%h req=%b mis=%b, expected 1 9 00 cafe0001 00000120 0 0",
                     RegWriteW, RdW, ResultSrcW, ALUResultW, PCPlus4W, o_req0, o_mis);
        end
    endtask

    task automatic test_timeout();
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'd0, 32'h124, 5'd13, 1000, 32'h0);
        n_tests++;
        if ({o_hung, o_berr, RegWriteW, RdW} !== {1'b0, 1'b1, 1'b0, 5'd0} || o_stall !== TO) begin
            n_fail++;
            $display("FAIL timeout: got hung=%b berr=%b rw=%b rd=%0d stall=%0d, expected 0 1 0 0 %0d",
                     o_hung, o_berr, RegWriteW, RdW, o_stall, TO);
        end
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h304, 32'd0, 32'h128, 5'd14, 0, 32'hA5A5_0F0F);
        n_tests++;
        if ({o_stall == 0, o_berr, ReadDataW, RegWriteW} !== {1'b1, 1'b0, 32'hA5A50F0F, 1'b1}) begin
            n_fail++;
            $display("FAIL after_timeout: got stall=%0d berr=%b data=%h rw=%b, expected 0 0 a5a50f0f 1",
                     o_stall, o_berr, ReadDataW, RegWriteW);
        end
    endtask

    task automatic test_reset_in_wait();
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        Funct3M    = 3'b010;
        ALUResultM = 32'h400;
        RdM        = 5'd15;
        dmem_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({dmem_req, StallM} !== 2'b11) begin
            n_fail++;
            $display("FAIL wait_entry: got req/stall=%b, expected 11", {dmem_req, StallM});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        set_nop();
        @(posedge clk); #1;
        reset      = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        n_tests++;
        if ({dmem_req, StallM} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_in_wait: got req/stall=%b, expected 00", {dmem_req, StallM});
        end
        @(posedge clk); #1;
        set_nop();
    endtask

    task automatic test_random();
        int          kind, lat;
        logic [2:0]  f3;
        logic [31:0] a, wd, pc4, rdata;
        logic [4:0]  rd;
        logic        rw, mw, mis;
        logic [1:0]  rs;
        logic [2:0]  load_f3 [5];
        load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 300; n++) begin
            kind  = $urandom_range(0, 3);
            a     = $urandom();
            wd    = $urandom();
            pc4   = $urandom();
            rdata = $urandom();
            rd    = 5'($urandom_range(1, 31));
            lat   = $urandom_range(0, 3);
            f3    = 3'b000;
            case (kind)
                0: begin rw = 1'b1; rs = 2'b00; mw = 1'b0; lat = 0; end
                1: begin rw = 1'b1; rs = 2'b10; mw = 1'b0; lat = 0; end
                2: begin rw = 1'b1; rs = 2'b01; mw = 1'b0; f3 = load_f3[$urandom_range(0, 4)]; end
                default: begin rw = 1'b0; rs = 2'b00; mw = 1'b1; f3 = 3'($urandom_range(0, 2)); end
            endcase
            mis = (kind >= 2) && ref_misaligned(f3, a);
            issue(rw, rs, mw, f3, a, wd, pc4, rd, lat, rdata);
            if (mis) begin
                n_tests++;
                if ({o_req0, o_mis, RegWriteW, RdW} !== {1'b0, 1'b1, 1'b0, 5'd0} || o_stall !== 0) begin
                    n_fail++;
                    $display("FAIL rnd_misalign #%0d: got req=%b mis=%b rw=%b rd=%0d stall=%0d, expected 0 1 0 0 0",
                             n, o_req0, o_mis, RegWriteW, RdW, o_stall);
                end
            end else begin
                n_tests++;
                if ({RegWriteW, RdW, ResultSrcW, ALUResultW, PCPlus4W, o_mis} !== {rw, rd, rs, a, pc4, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_wb #%0d: got rw=%b rd=%0d rs=%b alu=%h pc4=%h mis=%b, expected %b %0d %b %h %h 0",
                             n, RegWriteW, RdW, ResultSrcW, ALUResultW, PCPlus4W, o_mis, rw, rd, rs, a, pc4);
                end
                if (kind >= 2) begin
                    n_tests++;
                    if ({o_req0, o_we0, o_addr0, o_be0} !== {1'b1, mw, a & 32'hFFFFFFFC, ref_be(f3, a, mw)} ||
                        o_stall !== lat || o_hung || o_addr_moved || o_bubbles_bad != 0) begin
                        n_fail++;
                        $display("FAIL rnd_bus #%0d: got req=%b we=%b addr=%h be=%b stall=%0d moved=%b, expected 1 %b %h %b %0d 0",
                                 n, o_req0, o_we0, o_addr0, o_be0, o_stall, o_addr_moved,
                                 mw, a & 32'hFFFFFFFC, ref_be(f3, a, mw), lat);
                    end
                end else begin
                    n_tests++;
                    if (o_req0 !== 1'b0 || o_stall !== 0) begin
                        n_fail++;
                        $display("FAIL rnd_alu_req #%0d: got req=%b stall=%0d, expected 0 0", n, o_req0, o_stall);
                    end
                end
                if (kind == 2) begin
                    n_tests++;
                    if (ReadDataW !== ref_load(f3, a, rdata)) begin
                        n_fail++;
                        $display("FAIL rnd_load #%0d: f3=%0d addr=%h rdata=%h got %h, expected %h",
                                 n, f3, a, rdata, ReadDataW, ref_load(f3, a, rdata));
                    end
                end
                if (kind == 3) begin
                    n_tests++;
                    if (o_wdata0 !== ref_wdata(f3, wd)) begin
                        n_fail++;
                        $display("FAIL rnd_wdata #%0d: f3=%0d rs2=%h got %h, expected %h",
                                 n, f3, wd, o_wdata0, ref_wdata(f3, wd));
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_nop();
        test_reset();
        test_loads();
        test_store();
        test_stall();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
